// File: rtl/axis_image_vip_config.sv
// ============================================================================
//  Module   : axis_image_vip_config (package)
//  Purpose  : Shared configuration for the AXI-Stream image FIFO slice:
//             sink width, frame counter width and the FIFO entry layout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_image_vip_config;

  localparam int SINK_BYTES     = 4;
  localparam int FRAME_CNT_BITS = 16;

  // One FIFO slot: a beat's payload with its sideband flags
  typedef struct packed {
    logic [SINK_BYTES*8-1:0] data;
    logic                    last;
    logic                    user;
  } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/axis_geom_checker.sv
// ============================================================================
//  Module   : axis_geom_checker
//  Purpose  : Tracks column/row of accepted input beats and flags line-length
//             and frame-start violations; counts completed frames.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_geom_checker
  import axis_image_vip_config::*;
#(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      beat_i,
  input  logic                      last_i,
  input  logic                      user_i,
  output logic                      line_err_o,
  output logic                      frame_err_o,
  output logic [FRAME_CNT_BITS-1:0] frame_cnt_o
);

  localparam int c_col_bits = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int c_row_bits = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [c_col_bits-1:0] c_col_last = c_col_bits'(IMG_WIDTH - 1);
  localparam logic [c_row_bits-1:0] c_row_last = c_row_bits'(IMG_HEIGHT - 1);

  logic [c_col_bits-1:0]     r_col;
  logic [c_row_bits-1:0]     r_row;
  logic                      r_line_err;
  logic                      r_frame_err;
  logic [FRAME_CNT_BITS-1:0] r_frame_cnt;

  logic [c_col_bits-1:0] w_col;
  logic [c_row_bits-1:0] w_row;
  logic                  w_line_err;
  logic                  w_frame_err;
  logic                  w_eol;

  // A start-of-frame beat re-anchors itself at (0,0) for the line check
  always_comb begin
    w_col       = user_i ? '0 : r_col;
    w_row       = user_i ? '0 : r_row;
    w_line_err  = last_i ? (w_col != c_col_last) : (w_col == c_col_last);
    w_frame_err = user_i ? ((r_row != '0) || (r_col != '0))
                         : ((r_row == '0) && (r_col == '0));
    w_eol       = last_i || (w_col == c_col_last);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_col       <= '0;
      r_row       <= '0;
      r_line_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_line_err  <= beat_i & w_line_err;
      r_frame_err <= beat_i & w_frame_err;
      if (beat_i) begin
        r_col <= w_eol ? '0 : w_col + 1'b1;
        if (last_i) begin
          if (w_row == c_row_last) begin
            r_row       <= '0;
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end else begin
            r_row <= w_row + 1'b1;
          end
        end else begin
          r_row <= w_row;
        end
      end
    end
  end

  assign line_err_o  = r_line_err;
  assign frame_err_o = r_frame_err;
  assign frame_cnt_o = r_frame_cnt;

endmodule

`default_nettype wire

// File: rtl/axis_frame_fifo.sv
// ============================================================================
//  Module   : axis_frame_fifo
//  Purpose  : First-word-fall-through AXI-Stream FIFO with optional video
//             geometry checker (enabled by AXIS_FRAME_FIFO_CHECK_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_frame_fifo
  import axis_image_vip_config::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_BITS  = SINK_BYTES * 8,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [DATA_BITS-1:0]      axis_s_data_i,
  input  logic                      axis_s_valid_i,
  output logic                      axis_s_ready_o,
  input  logic                      axis_s_last_i,
  input  logic                      axis_s_user_i,
  output logic [DATA_BITS-1:0]      axis_m_data_o,
  output logic                      axis_m_valid_o,
  input  logic                      axis_m_ready_i,
  output logic                      axis_m_last_o,
  output logic                      axis_m_user_o,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      line_err_o,
  output logic                      frame_err_o,
  output logic [FRAME_CNT_BITS-1:0] frame_cnt_o
);

  localparam int c_addr_bits = $clog2(DEPTH);
  localparam logic [c_addr_bits:0] c_full = DEPTH[c_addr_bits:0];

  fifo_entry_t            r_mem [DEPTH];
  logic [c_addr_bits-1:0] r_wr_ptr;
  logic [c_addr_bits-1:0] r_rd_ptr;
  logic [c_addr_bits:0]   r_level;

  logic        w_push;
  logic        w_pop;
  fifo_entry_t w_wr_entry;
  fifo_entry_t w_rd_entry;

  // Ready is held low while reset is applied, independent of the stale level
  assign axis_s_ready_o = !rst_i && (r_level != c_full);
  assign axis_m_valid_o = (r_level != '0);
  assign w_push         = axis_s_valid_i & axis_s_ready_o;
  assign w_pop          = axis_m_valid_o & axis_m_ready_i;

  always_comb begin
    w_wr_entry      = '0;
    w_wr_entry.data = axis_s_data_i;
    w_wr_entry.last = axis_s_last_i;
    w_wr_entry.user = axis_s_user_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_rd_entry    = r_mem[r_rd_ptr];
  assign axis_m_data_o = w_rd_entry.data;
  assign axis_m_last_o = w_rd_entry.last;
  assign axis_m_user_o = w_rd_entry.user;
  assign level_o       = r_level;

`ifdef AXIS_FRAME_FIFO_CHECK_EN
  axis_geom_checker #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_geom_checker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .beat_i      (w_push),
    .last_i      (axis_s_last_i),
    .user_i      (axis_s_user_i),
    .line_err_o  (line_err_o),
    .frame_err_o (frame_err_o),
    .frame_cnt_o (frame_cnt_o)
  );
`else
  assign line_err_o  = 1'b0;
  assign frame_err_o = 1'b0;
  assign frame_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_frame_fifo.sv
// ============================================================================
//  Module   : tb_axis_frame_fifo
//  Purpose  : Directed scoreboard bench for axis_frame_fifo.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_frame_fifo;
  import axis_image_vip_config::*;

  localparam int DEPTH = 16;
  localparam int DW    = SINK_BYTES * 8;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef AXIS_FRAME_FIFO_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [DW-1:0]             s_data;
  logic                      s_valid;
  logic                      s_ready;
  logic                      s_last;
  logic                      s_user;
  logic [DW-1:0]             m_data;
  logic                      m_valid;
  logic                      m_ready;
  logic                      m_last;
  logic                      m_user;
  logic [LW-1:0]             level;
  logic                      line_err;
  logic                      frame_err;
  logic [FRAME_CNT_BITS-1:0] frame_cnt;

  always #5 clk = ~clk;

  axis_frame_fifo #(
    .DEPTH      (DEPTH),
    .DATA_BITS  (DW),
    .IMG_WIDTH  (8),
    .IMG_HEIGHT (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .axis_s_data_i  (s_data),
    .axis_s_valid_i (s_valid),
    .axis_s_ready_o (s_ready),
    .axis_s_last_i  (s_last),
    .axis_s_user_i  (s_user),
    .axis_m_data_o  (m_data),
    .axis_m_valid_o (m_valid),
    .axis_m_ready_i (m_ready),
    .axis_m_last_o  (m_last),
    .axis_m_user_o  (m_user),
    .level_o        (level),
    .line_err_o     (line_err),
    .frame_err_o    (frame_err),
    .frame_cnt_o    (frame_cnt)
  );

  fifo_entry_t sb_q[$];
  int checks = 0;
  int errors = 0;
  int line_pulses = 0;
  int frame_pulses = 0;
  int popped = 0;
  logic last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample everything at the falling edge: record accepted input beats,
  // compare delivered beats against the queue head, count error pulses.
  task automatic neg_sample();
    fifo_entry_t e;
    @(negedge clk);
    if (line_err)  line_pulses++;
    if (frame_err) frame_pulses++;
    last_acc = !rst && s_valid && s_ready;
    if (last_acc) begin
      e      = '0;
      e.data = s_data;
      e.last = s_last;
      e.user = s_user;
      sb_q.push_back(e);
    end
    if (!rst && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("m_data", m_data, e.data);
        check("m_last", {31'd0, m_last}, {31'd0, e.last});
        check("m_user", {31'd0, m_user}, {31'd0, e.user});
        popped++;
      end
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    neg_sample();
    to_pos();
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l, input logic u);
    int n;
    n       = 0;
    s_data  = d;
    s_last  = l;
    s_user  = u;
    s_valid = 1'b1;
    do begin
      neg_sample();
      to_pos();
      n++;
    end while (!last_acc && n < 200);
    s_valid = 1'b0;
    if (!last_acc) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n       = 0;
    m_ready = 1'b1;
    while (level != '0 && n < 200) begin
      tick();
      n++;
    end
    m_ready = 1'b0;
    check("drain_level", level, 32'd0);
    check("drain_sb_empty", sb_q.size(), 32'd0);
  endtask

  // One 8x4 frame; bad_line makes line 1 end at column 5 and bad_sof
  // restarts the frame on what would have been line 2.
  task automatic send_frame(input logic [7:0] tag, input bit bad);
    int lens[6];
    int nlines;
    if (bad) begin
      lens   = '{8, 6, 8, 8, 8, 8};
      nlines = 6;
    end else begin
      lens   = '{8, 8, 8, 8, 0, 0};
      nlines = 4;
    end
    for (int r = 0; r < nlines; r++) begin
      for (int c = 0; c < lens[r]; c++) begin
        push_beat({tag, 8'(r), 16'(c)}, c == lens[r] - 1, (c == 0) && (r == 0 || (bad && r == 2)));
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_data  = '0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_user  = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    neg_sample();
    check("rst_level", level, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_line_err", {31'd0, line_err}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    to_pos();
    rst = 1'b0;
    neg_sample();
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    to_pos();

    // Four beats with the output stalled, then released in order
    check("empty_m_valid", {31'd0, m_valid}, 32'd0);
    push_beat(32'hA000, 1'b0, 1'b0);
    check("latency_m_valid", {31'd0, m_valid}, 32'd1);
    check("latency_level", level, 32'd1);
    for (int i = 1; i < 4; i++) push_beat(32'hA000 + i, 1'b0, 1'b0);
    check("four_level", level, 32'd4);
    check("four_s_ready", {31'd0, s_ready}, 32'd1);
    tick();
    tick();
    check("stall_head_data", m_data, 32'hA000);
    check("stall_head_valid", {31'd0, m_valid}, 32'd1);
    drain();
    check("four_popped", popped, 32'd4);

    // Fill to full across the pointer wrap, then hold a 17th beat
    for (int i = 0; i < 16; i++) push_beat(32'hB000 + i, i[0], 1'b0);
    check("full_level", level, 32'd16);
    check("full_s_ready", {31'd0, s_ready}, 32'd0);
    s_data  = 32'hC0DE;
    s_last  = 1'b1;
    s_user  = 1'b0;
    s_valid = 1'b1;
    tick();
    tick();
    tick();
    check("held_level", level, 32'd16);
    check("held_sb_size", sb_q.size(), 32'd16);

    // Full with both sides active: one pop, no push
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    neg_sample();
    check("full_pop_level", level, 32'd15);
    check("full_pop_s_ready", {31'd0, s_ready}, 32'd1);
    to_pos();
    s_valid = 1'b0;
    check("refill_level", level, 32'd16);
    drain();

    // Geometry starts from a clean (0,0) position
    rst = 1'b1;
    tick();
    rst = 1'b0;
    to_pos();
    line_pulses  = 0;
    frame_pulses = 0;
    m_ready      = 1'b1;
    send_frame(8'h51, 1'b0);
    tick();
    tick();
    tick();
    check("good_line_pulses", line_pulses, 32'd0);
    check("good_frame_pulses", frame_pulses, 32'd0);
    check("good_frame_cnt", frame_cnt, 32'(CHK));

    popped = 0;
    send_frame(8'h52, 1'b1);
    tick();
    tick();
    tick();
    check("bad_line_pulses", line_pulses, 32'(CHK));
    check("bad_frame_pulses", frame_pulses, 32'(CHK));
    check("bad_frame_cnt", frame_cnt, 32'(2 * CHK));
    drain();
    check("bad_all_delivered", popped, 32'd46);

    // Mid-stream reset discards stored beats
    for (int i = 0; i < 7; i++) push_beat(32'hD000 + i, 1'b0, i == 0);
    check("pre_rst_level", level, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    neg_sample();
    check("mid_rst_level", level, 32'd0);
    check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_frame_cnt", frame_cnt, 32'd0);
    check("mid_rst_s_ready", {31'd0, s_ready}, 32'd1);
    sb_q.delete();
    to_pos();
    push_beat(32'hE001, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axis_frame_fifo.md
AXIS_FRAME_FIFO -- requirements
Module: axis_frame_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter DATA_BITS, default SINK_BYTES*8, data width.
REQ-003 SHALL have parameter IMG_WIDTH, default 8, pixels (beats) per line.
REQ-004 SHALL have parameter IMG_HEIGHT, default 4, lines per frame.
REQ-005 SHALL have ports; one clock; reset is synchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- axis_s_data_i  in  DATA_BITS  slave data
- axis_s_valid_i  in  1  slave valid
- axis_s_ready_o  out  1  slave ready
- axis_s_last_i  in  1  end of line
- axis_s_user_i  in  1  start of frame
- axis_m_data_o  out  DATA_BITS  master data
- axis_m_valid_o  out  1  master valid
- axis_m_ready_i  in  1  master ready
- axis_m_last_o  out  1  end of line
- axis_m_user_o  out  1  start of frame
- level_o  out  clog2(DEPTH)+1  occupied entries
- line_err_o  out  1  one-cycle line-length error pulse
- frame_err_o  out  1  one-cycle frame-structure error pulse
- frame_cnt_o  out  16  completed frames, wraps

Function
REQ-006 SHALL accept a beat when axis_s_valid_i and axis_s_ready_o are both high, storing {data, last, user} as one entry.
REQ-007 SHALL drive axis_s_ready_o = (level_o != DEPTH); no write bypass when full, even with a simultaneous read.
REQ-008 SHALL drive axis_m_valid_o = (level_o != 0); the head entry is presented first-word-fall-through on axis_m_data_o/last/user.
REQ-009 SHALL pop the head entry when axis_m_valid_o and axis_m_ready_i are both high.
REQ-010 SHALL have a latency of 1 cycle from acceptance into an empty FIFO to axis_m_valid_o high.
REQ-011 SHALL leave level_o unchanged on a simultaneous push and pop, and otherwise change it by +1 (push) or -1 (pop).
REQ-012 SHALL hold master outputs stable while axis_m_valid_o is high and axis_m_ready_i is low.
REQ-013 SHALL wrap read/write pointers modulo DEPTH; ordering preserved across wrap.
REQ-014 SHALL track column 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1 on accepted input beats only.
REQ-015 SHALL pulse line_err_o the cycle after a beat with last=1 at column != IMG_WIDTH-1, or last=0 at column IMG_WIDTH-1; column resets to 0 after any last=1 beat or after column IMG_WIDTH-1.
REQ-016 SHALL pulse frame_err_o the cycle after a user=1 beat not at (row 0, column 0), or a user=0 beat at (row 0, column 0); a user=1 beat always forces its own position to (0,0).
REQ-017 SHALL increment frame_cnt_o (16-bit wrap) on an accepted beat at row IMG_HEIGHT-1 with last=1, then reset row to 0.
REQ-018 SHALL pass data unmodified regardless of errors; errors never drop or insert beats.

Reset
REQ-019 SHALL, when rst_i is high at a clock edge, empty the FIFO: level_o=0, axis_m_valid_o=0, axis_s_ready_o=0 during reset, 1 the cycle after release.
REQ-020 SHALL reset to 0: row, column, line_err_o, frame_err_o, frame_cnt_o; entries stored before a mid-stream reset are discarded.
REQ-021 SHALL reset no storage RAM contents; master data/last/user are don't-care while axis_m_valid_o=0.

Configuration
REQ-022 SHALL compile in the geometry checker (REQ-014..017) only when AXIS_FRAME_FIFO_CHECK_EN is defined.
REQ-023 SHALL, without AXIS_FRAME_FIFO_CHECK_EN, tie line_err_o, frame_err_o and frame_cnt_o to 0; FIFO behaviour is identical either way.

Structure
REQ-024 SHALL take SINK_BYTES from axis_image_vip_config, and the shared package SHALL hold the FIFO entry struct typedef (data, last, user) and the FRAME_CNT_BITS=16 constant.
REQ-025 SHALL place the checker in sub-module axis_geom_checker, instantiated under the macro and observing the slave handshake.

Verification
REQ-026 SHALL cover: 4 beats pushed with axis_m_ready_i=0 -> level_o=4, ready high; then ready=1 -> beats out in order, level_o back to 0.
REQ-027 SHALL cover: 17 pushes into DEPTH=16 with no pops -> 16th push sets level_o=16, axis_s_ready_o=0, and the 17th beat is held, not accepted.
REQ-028 SHALL cover: full FIFO with valid=1 and ready=1 on both sides -> exactly one pop, no push that cycle, level_o=15 next cycle.
REQ-029 SHALL cover: a correct 8x4 frame, user on beat 0 and last on every 8th beat -> no error pulses, frame_cnt_o=1.
REQ-030 SHALL cover: last on column 5 -> line_err_o high for exactly one cycle; user on row 2 -> frame_err_o high for one cycle, and all beats still delivered.
REQ-031 SHALL cover: rst_i asserted for 1 cycle with level_o=7 -> next cycle level_o=0, axis_m_valid_o=0, frame_cnt_o=0.
